// File: rtl/weight_fetch_nbank_if.sv
// Shared read bus between the weight fetcher and its NUM_KERNEL weight bram_ctrl banks.
// Each mem_rden cycle is exactly one read of mem_addr in every bank. Each bank answers with
// mem_oval[k] MEM_LATENCY cycles later. The bus has no ready signal: the requester never
// issues more reads than it has room to absorb.
interface weight_fetch_nbank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_KERNEL = 4
);
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic                             mem_rden;
    logic [NUM_KERNEL*DATA_WIDTH-1:0] mem_odat;
    logic [NUM_KERNEL-1:0]            mem_oval;

    modport master (output mem_addr, mem_rden, input mem_odat, mem_oval);
    modport slave  (input mem_addr, mem_rden, output mem_odat, mem_oval);
endinterface

// File: rtl/weight_fetch_nbank.sv
// Lockstep weight fetch across NUM_KERNEL banks, using credit-limited issue.
// Results are packed kernel-major into a FIFO that drains under consumer stall.
module weight_fetch_nbank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_STEP   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_start,
    input  logic [ADDR_WIDTH-1:0]                   i_conf_baseaddr,
    input  logic [31:0]                             i_conf_numword,
    input  logic                                    i_req,
    output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_dat,
    output logic                                    o_vld,
    input  logic                                    i_stall,
    weight_fetch_nbank_if.master                    mem,
    output logic [3:0]                              o_status
);
    localparam int EW = BIT_WIDTH * NUM_CHANNEL;
    localparam int VW = EW * NUM_KERNEL;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rden_q;
    logic [31:0]           numword;
    logic [31:0]           idx;
    logic [CW-1:0]         pending;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [VW-1:0]         fifo_mem [FIFO_DEPTH];
    logic                  err_ovf;
    logic                  err_align;

    logic          ret_all;
    logic          ret_mixed;
    logic          ret_dec;
    logic [CW:0]   inflight;
    logic          issue;
    logic          req_run;
    logic          push;
    logic          pop;
    logic          fifo_clr;
    logic          load_cfg;
    logic [VW-1:0] push_word;
    logic          unused_bits;

    assign ret_all   = &mem.mem_oval;
    assign ret_mixed = (|mem.mem_oval) && !ret_all;
    assign ret_dec   = (ret_all || ret_mixed) && (outstanding != '0);
    assign inflight  = {1'b0, outstanding} + {1'b0, count};
    // A read is only issued when its result is guaranteed a FIFO slot.
    assign issue     = (state == RUN) && !i_start && (pending != '0)
                       && (inflight < (CW+1)'(FIFO_DEPTH));
    assign req_run   = i_req && (state == RUN);
    assign push      = ret_all && (state == RUN);
    assign pop       = o_vld && !i_stall;
    assign fifo_clr  = (state == FLUSH) || ((state == RUN) && i_start);
    assign load_cfg  = ((state == IDLE) && i_start)
                       || ((state == FLUSH) && (outstanding == '0));

    always_comb begin
        push_word = '0;
        for (int k = 0; k < NUM_KERNEL; k++)
            push_word[k*EW +: EW] = mem.mem_odat[k*DATA_WIDTH +: EW];
    end

    assign o_vld        = (count != '0);
    assign o_dat        = fifo_mem[rd_ptr];
    assign o_status     = {err_align, err_ovf, state};
    assign mem.mem_addr = addr_q;
    assign mem.mem_rden = rden_q;
    assign unused_bits  = (^mem.mem_odat) ^ (MEM_LATENCY < 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            off         <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            numword     <= 32'd1;
            idx         <= '0;
            pending     <= '0;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            err_ovf     <= 1'b0;
            err_align   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            rden_q      <= issue;
            outstanding <= outstanding + CW'(issue) - CW'(ret_dec);
            if (ret_mixed) err_align <= 1'b1;

            if (issue && !req_run) begin
                pending <= pending - CW'(1);
            end else if (req_run && !issue) begin
                if (pending == CW'(FIFO_DEPTH)) err_ovf <= 1'b1;
                else                            pending <= pending + CW'(1);
            end

            if (issue) begin
                addr_q <= base + off;
                if (idx == numword - 32'd1) begin
                    idx <= '0;
                    off <= '0;
                end else begin
                    idx <= idx + 32'd1;
                    off <= off + ADDR_WIDTH'(ADDR_STEP);
                end
            end

            if (fifo_clr) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= push_word;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end

            // Restart lands here from IDLE directly or from FLUSH once all reads are back.
            if (load_cfg) begin
                base    <= i_conf_baseaddr;
                numword <= (i_conf_numword == 32'd0) ? 32'd1 : i_conf_numword;
                idx     <= '0;
                off     <= '0;
                pending <= '0;
            end

            case (state)
                IDLE:    if (i_start) state <= RUN;
                RUN:     if (i_start) state <= FLUSH;
                FLUSH:   if (outstanding == '0) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch_nbank.sv
// Directed and randomized bench for weight_fetch_nbank, with a latency-accurate bank model.
// A queue-based reference model supplies the expected addresses and vectors.
module tb_weight_fetch_nbank;
    localparam int DW = 32, AW = 32, BW = 8, NC = 3, NK = 4, LAT = 2, FD = 4, STEP = 4;
    localparam int EW = BW * NC;
    localparam int VW = EW * NK;

    logic          clk = 1'b0;
    logic          rst, i_start, i_req, i_stall;
    logic [AW-1:0] i_conf_baseaddr;
    logic [31:0]   i_conf_numword;
    logic [VW-1:0] o_dat;
    logic          o_vld;
    logic [3:0]    o_status;

    weight_fetch_nbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_KERNEL(NK)) mem_bus ();

    weight_fetch_nbank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_WIDTH(BW), .NUM_CHANNEL(NC),
        .NUM_KERNEL(NK), .MEM_LATENCY(LAT), .FIFO_DEPTH(FD), .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_conf_baseaddr(i_conf_baseaddr),
        .i_conf_numword(i_conf_numword), .i_req(i_req), .o_dat(o_dat), .o_vld(o_vld),
        .i_stall(i_stall), .mem(mem_bus), .o_status(o_status)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bank model ----------------
    int            bank_mode;
    bit            skew2;
    logic [LAT:0]  rden_p;
    logic [AW-1:0] addr_p [LAT+1];

    function automatic logic [DW-1:0] bank_word(int k, logic [AW-1:0] a, int mode);
        if (mode == 0) return {8'h00, 8'(k), 8'(k + 1), 8'(k + 2)};
        return {8'hEE, a[9:2], 8'(k * 17), a[7:0] ^ 8'(k)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rden_p <= '0;
        end else begin
            rden_p[0] <= mem_bus.mem_rden;
            addr_p[0] <= mem_bus.mem_addr;
            for (int i = 1; i <= LAT; i++) begin
                rden_p[i] <= rden_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    always_comb begin
        mem_bus.mem_odat = '0;
        mem_bus.mem_oval = '0;
        for (int k = 0; k < NK; k++) begin
            if (skew2 && k == 2) begin
                mem_bus.mem_oval[k]           = rden_p[LAT];
                mem_bus.mem_odat[k*DW +: DW]  = bank_word(k, addr_p[LAT], bank_mode);
            end else begin
                mem_bus.mem_oval[k]           = rden_p[LAT-1];
                mem_bus.mem_odat[k*DW +: DW]  = bank_word(k, addr_p[LAT-1], bank_mode);
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [AW-1:0] m_base;
    int            m_num, m_idx;
    bit            m_flush;
    logic [AW-1:0] ea;
    logic [VW-1:0] exp_q [$];
    int            rden_cnt, pop_cnt, first_rden, first_vld;
    int            n_vec, n_err;

    function automatic logic [VW-1:0] exp_vec(logic [AW-1:0] a, int mode);
        logic [DW-1:0] w;
        exp_vec = '0;
        for (int k = 0; k < NK; k++) begin
            w = bank_word(k, a, mode);
            exp_vec[k*EW +: EW] = w[EW-1:0];
        end
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !m_flush) begin
            if (mem_bus.mem_rden) begin
                ea = m_base + AW'(m_idx * STEP);
                check("mem_addr", mem_bus.mem_addr, ea);
                exp_q.push_back(exp_vec(ea, bank_mode));
                m_idx = (m_idx + 1) % m_num;
                rden_cnt++;
                if (first_rden < 0) first_rden = cyc;
            end
            if (o_vld && !i_stall) begin
                pop_cnt++;
                if (first_vld < 0) first_vld = cyc;
                check("pop_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("o_dat", o_dat, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_cfg(logic [AW-1:0] base, int num);
        i_start         = 1'b1;
        i_conf_baseaddr = base;
        i_conf_numword  = 32'(num);
        m_base = base;
        m_num  = (num == 0) ? 1 : num;
        m_idx  = 0;
        exp_q.delete();
        step(1);
        i_start = 1'b0;
    endtask

    task automatic send_reqs(int n);
        for (int i = 0; i < n; i++) begin
            i_req = 1'b1;
            step(1);
        end
        i_req = 1'b0;
    endtask

    task automatic wait_pops(int target);
        for (int i = 0; i < 300 && pop_cnt < target; i++) step(1);
    endtask

    task automatic do_reset();
        m_flush = 1'b1;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_stall = 1'b0;
        skew2   = 1'b0;
        step(2);
        @(negedge clk);
        check("rst_status", o_status, 4'h0);
        check("rst_vld", o_vld, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_flush = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    int r0, p0, reqs, k_seen, est;
    logic [AW-1:0] rbase;
    int rnum;

    initial begin
        rst = 1'b1; i_start = 1'b0; i_req = 1'b0; i_stall = 1'b0;
        i_conf_baseaddr = '0; i_conf_numword = '0;
        bank_mode = 1; skew2 = 1'b0; m_flush = 1'b1;
        m_base = '0; m_num = 1; m_idx = 0;
        rden_cnt = 0; pop_cnt = 0; first_rden = -1; first_vld = -1;
        n_vec = 0; n_err = 0;

        // reset state
        step(3);
        @(negedge clk);
        check("rst_o_vld", o_vld, 1'b0);
        check("rst_o_dat", o_dat, '0);
        check("rst_mem_rden", mem_bus.mem_rden, 1'b0);
        check("rst_mem_addr", mem_bus.mem_addr, '0);
        check("rst_o_status", o_status, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_flush = 1'b0;

        // basic fetch with address wrap
        start_cfg(32'h100, 3);
        @(negedge clk);
        check("t1_state_run", o_status[1:0], 2'd1);
        @(posedge clk);
        #1;
        first_rden = -1; first_vld = -1; r0 = rden_cnt; p0 = pop_cnt;
        send_reqs(5);
        wait_pops(p0 + 5);
        step(4);
        check("t1_issues", rden_cnt - r0, 5);
        check("t1_pops", pop_cnt - p0, 5);
        check("t1_latency", first_vld - first_rden, LAT + 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // fixed bank pattern packing
        bank_mode = 0;
        p0 = pop_cnt;
        send_reqs(1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_vld) break;
        end
        check("t2_vld", o_vld, 1'b1);
        check("t2_const", o_dat, 96'h030405_020304_010203_000102);
        @(posedge clk);
        #1;
        wait_pops(p0 + 1);
        step(3);
        bank_mode = 1;

        // stall: credits cap issue at FIFO_DEPTH
        i_stall = 1'b1;
        r0 = rden_cnt; p0 = pop_cnt;
        send_reqs(8);
        step(12);
        @(negedge clk);
        check("t3_issues", rden_cnt - r0, 4);
        check("t3_full_vld", o_vld, 1'b1);
        check("t3_head", o_dat, exp_q[0]);
        check("t3_ovf_clear", o_status[2], 1'b0);
        @(posedge clk);
        #1;
        step(5);
        @(negedge clk);
        check("t3_head_stable", o_dat, exp_q[0]);
        check("t3_no_pops", pop_cnt - p0, 0);
        @(posedge clk);
        #1;

        // one request past the credit limit
        send_reqs(1);
        step(3);
        @(negedge clk);
        check("t4_ovf_set", o_status[2], 1'b1);
        check("t4_issues_held", rden_cnt - r0, 4);
        @(posedge clk);
        #1;
        i_stall = 1'b0;
        wait_pops(p0 + 8);
        step(10);
        check("t34_pops", pop_cnt - p0, 8);
        check("t4_not_served", rden_cnt - r0, 8);
        check("t4_ovf_sticky", o_status[2], 1'b1);
        check("t34_queue_empty", exp_q.size(), 0);

        // randomized traffic and stall
        for (int run = 0; run < 3; run++) begin
            do_reset();
            rbase = (run == 2) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            rnum  = $urandom_range(0, 5);
            start_cfg(rbase, rnum);
            r0 = rden_cnt; p0 = pop_cnt; reqs = 0;
            for (int c = 0; c < 150; c++) begin
                est     = reqs - (rden_cnt - r0);
                i_stall = ($urandom_range(0, 3) == 0);
                i_req   = ($urandom_range(0, 1) == 1) && (est < FD);
                if (i_req) reqs++;
                step(1);
            end
            i_req = 1'b0;
            i_stall = 1'b0;
            wait_pops(p0 + reqs);
            step(5);
            check("rnd_pops", pop_cnt - p0, reqs);
            check("rnd_queue_empty", exp_q.size(), 0);
            check("rnd_errors", o_status[3:2], 2'b00);
        end

        // restart during RUN with reads in flight
        do_reset();
        start_cfg(32'h200, 4);
        i_req = 1'b1;
        step(2);
        i_req = 1'b0;
        k_seen = 0;
        for (int i = 0; i < 10 && k_seen < 2; i++) begin
            if (mem_bus.mem_rden) k_seen++;
            if (k_seen < 2) step(1);
        end
        check("t6_inflight", k_seen, 2);
        m_flush = 1'b1;
        i_start = 1'b1;
        i_conf_baseaddr = 32'h300;
        i_conf_numword  = 32'd2;
        exp_q.delete();
        m_base = 32'h300; m_num = 2; m_idx = 0;
        step(1);
        i_start = 1'b0;
        @(negedge clk);
        check("t6_flush_state", o_status[1:0], 2'd2);
        for (int i = 0; i < 30; i++) begin
            if (o_status[1:0] == 2'd2) check("t6_flush_vld", o_vld, 1'b0);
            else break;
            @(negedge clk);
        end
        check("t6_back_run", o_status[1:0], 2'd1);
        @(posedge clk);
        #1;
        m_flush = 1'b0;
        r0 = rden_cnt; p0 = pop_cnt;
        send_reqs(2);
        wait_pops(p0 + 2);
        step(3);
        check("t6_issues", rden_cnt - r0, 2);
        check("t6_pops", pop_cnt - p0, 2);

        // bank 2 returns one cycle late
        do_reset();
        start_cfg(32'h40, 2);
        skew2 = 1'b1;
        p0 = pop_cnt;
        send_reqs(1);
        step(10);
        @(negedge clk);
        check("t5_err_align", o_status[3], 1'b1);
        check("t5_no_push", pop_cnt - p0, 0);
        check("t5_vld_low", o_vld, 1'b0);
        @(posedge clk);
        #1;
        exp_q.delete();
        skew2 = 1'b0;

        // reset in the middle of RUN
        do_reset();
        start_cfg(32'h80, 3);
        i_stall = 1'b1;
        send_reqs(3);
        step(4);
        @(negedge clk);
        check("mid_vld_before", o_vld, 1'b1);
        @(posedge clk);
        #1;
        m_flush = 1'b1;
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check("mid_rst_vld", o_vld, 1'b0);
        check("mid_rst_dat", o_dat, '0);
        check("mid_rst_rden", mem_bus.mem_rden, 1'b0);
        check("mid_rst_addr", mem_bus.mem_addr, '0);
        check("mid_rst_status", o_status, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_stall = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
